// File: rtl/alu_sequencer.sv
// Sign-magnitude ALU sequencer: single-cycle add/sub, iterative shift-add multiply
// and restoring divide over one shared 2W-bit accumulator, saturating at MAX.
module alu_sequencer #(
  parameter int W   = 24,
  parameter int MAX = 9999999
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         clear,
  input  logic [1:0]   op,
  input  logic [W-1:0] a_mag,
  input  logic         a_neg,
  input  logic [W-1:0] b_mag,
  input  logic         b_neg,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] res_mag,
  output logic         res_neg,
  output logic [W-1:0] rem_mag,
  output logic         ovf,
  output logic         div0
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(W - 1);
  localparam logic [2*W-1:0] MAX_WIDE = (2 * W)'(MAX);

  logic [1:0]     state_reg;
  logic [1:0]     op_reg;
  logic [W-1:0]   a_reg, b_reg;
  logic           a_neg_reg, b_neg_reg;
  logic [2*W-1:0] acc_reg;
  logic [CW-1:0]  cnt_reg;
  logic [W-1:0]   res_mag_reg, rem_mag_reg;
  logic           res_neg_reg, ovf_reg, div0_reg;

  // add/sub datapath
  logic         eff_b_neg;
  logic [W:0]   add_sum;
  logic         a_ge_b;
  logic [W-1:0] sub_mag;

  // iterative datapath: mul keeps the partial product in the upper half and the
  // remaining multiplier bits in the lower half; div keeps remainder:quotient.
  logic [W:0]     mul_sum;
  logic [2*W-1:0] mul_next;
  logic [W:0]     div_tmp;
  logic           div_geq;
  logic [W-1:0]   div_rem;
  logic [2*W-1:0] div_next;
  logic [2*W-1:0] iter_next;

  logic           b_zero;
  logic           single_cycle;
  logic           run_last;

  logic [2*W-1:0] fin_wide;
  logic           fin_neg;
  logic [W-1:0]   fin_rem;
  logic           fin_div0;
  logic           fin_ovf;
  logic [W-1:0]   fin_mag;
  logic           fin_neg_final;

  always_comb begin
    eff_b_neg = b_neg_reg ^ op_reg[0];
    add_sum   = {1'b0, a_reg} + {1'b0, b_reg};
    a_ge_b    = (a_reg >= b_reg);
    sub_mag   = a_ge_b ? (a_reg - b_reg) : (b_reg - a_reg);

    mul_sum   = {1'b0, acc_reg[2*W-1:W]} + (acc_reg[0] ? {1'b0, a_reg} : {(W+1){1'b0}});
    mul_next  = {mul_sum, acc_reg[W-1:1]};

    div_tmp   = acc_reg[2*W-1:W-1];
    div_geq   = (div_tmp >= {1'b0, b_reg});
    // when div_geq the true difference is below b, so the low W bits are exact
    div_rem   = div_geq ? (div_tmp[W-1:0] - b_reg) : div_tmp[W-1:0];
    div_next  = {div_rem, acc_reg[W-2:0], div_geq};

    iter_next = op_reg[0] ? div_next : mul_next;

    b_zero       = (b_reg == '0);
    single_cycle = !op_reg[1] || (op_reg == OP_DIV && b_zero);
    run_last     = (state_reg == ST_RUN) && !clear && (single_cycle || cnt_reg == '0);
  end

  always_comb begin
    fin_wide = '0;
    fin_neg  = 1'b0;
    fin_rem  = '0;
    fin_div0 = 1'b0;
    case (op_reg)
      OP_ADD, OP_SUB: begin
        if (a_neg_reg == eff_b_neg) begin
          fin_wide = (2 * W)'(add_sum);
          fin_neg  = a_neg_reg;
        end else begin
          fin_wide = (2 * W)'(sub_mag);
          fin_neg  = a_ge_b ? a_neg_reg : eff_b_neg;
        end
      end
      OP_MUL: begin
        fin_wide = mul_next;
        fin_neg  = a_neg_reg ^ b_neg_reg;
      end
      default: begin
        if (b_zero) begin
          fin_div0 = 1'b1;
        end else begin
          fin_wide = (2 * W)'(div_next[W-1:0]);
          fin_rem  = div_next[2*W-1:W];
          fin_neg  = a_neg_reg ^ b_neg_reg;
        end
      end
    endcase
    fin_ovf       = (fin_wide > MAX_WIDE);
    fin_mag       = fin_ovf ? MAX_WIDE[W-1:0] : fin_wide[W-1:0];
    fin_neg_final = fin_neg && (fin_mag != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      op_reg      <= OP_ADD;
      a_reg       <= '0;
      b_reg       <= '0;
      a_neg_reg   <= 1'b0;
      b_neg_reg   <= 1'b0;
      acc_reg     <= '0;
      cnt_reg     <= '0;
      res_mag_reg <= '0;
      res_neg_reg <= 1'b0;
      rem_mag_reg <= '0;
      ovf_reg     <= 1'b0;
      div0_reg    <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start && !clear) begin
            state_reg <= ST_RUN;
            op_reg    <= op;
            a_reg     <= a_mag;
            b_reg     <= b_mag;
            a_neg_reg <= a_neg;
            b_neg_reg <= b_neg;
            acc_reg   <= {{W{1'b0}}, (op[0] ? a_mag : b_mag)};
            cnt_reg   <= CNT_LAST;
            ovf_reg   <= 1'b0;
            div0_reg  <= 1'b0;
          end
        end
        ST_RUN: begin
          if (clear) begin
            state_reg <= ST_IDLE;
          end else if (run_last) begin
            state_reg <= ST_DONE;
            if (!single_cycle) acc_reg <= iter_next;
          end else begin
            acc_reg <= iter_next;
            cnt_reg <= cnt_reg - CW'(1);
          end
        end
        default: state_reg <= ST_IDLE;
      endcase

      if (run_last) begin
        res_mag_reg <= fin_mag;
        res_neg_reg <= fin_neg_final;
        rem_mag_reg <= fin_rem;
        ovf_reg     <= fin_ovf;
        div0_reg    <= fin_div0;
      end
    end
  end

  assign busy    = (state_reg == ST_RUN);
  assign done    = (state_reg == ST_DONE);
  assign res_mag = res_mag_reg;
  assign res_neg = res_neg_reg;
  assign rem_mag = rem_mag_reg;
  assign ovf     = ovf_reg;
  assign div0    = div0_reg;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: directed vector table, multi-cycle corner sequences,
// and randomized operations checked against an integer-arithmetic model.
module tb_alu_sequencer;
  localparam int W   = 24;
  localparam int MAX = 9999999;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         clear = 1'b0;
  logic [1:0]   op = 2'd0;
  logic [W-1:0] a_mag = '0;
  logic         a_neg = 1'b0;
  logic [W-1:0] b_mag = '0;
  logic         b_neg = 1'b0;
  logic         busy, done, res_neg, ovf, div0;
  logic [W-1:0] res_mag, rem_mag;

  int     tests = 0;
  int     fails = 0;
  longint last_mag = 0;
  bit     last_neg = 1'b0;

  always #5 clk = ~clk;

  alu_sequencer #(.W(W), .MAX(MAX)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear), .op(op),
    .a_mag(a_mag), .a_neg(a_neg), .b_mag(b_mag), .b_neg(b_neg),
    .busy(busy), .done(done), .res_mag(res_mag), .res_neg(res_neg),
    .rem_mag(rem_mag), .ovf(ovf), .div0(div0)
  );

  typedef struct {
    string  name;
    int     op;
    longint a;
    bit     an;
    longint b;
    bit     bn;
    longint mag;
    bit     neg;
    longint rem;
    bit     ovf;
    bit     d0;
    int     t;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Signed integer arithmetic straight from the operation definitions.
  function automatic void model(input int o, input longint a, input bit an,
                                input longint b, input bit bn,
                                output longint mag, output bit neg, output longint rem,
                                output bit ov, output bit d0, output int t);
    longint sa, sb, r;
    sa = an ? -a : a;
    sb = bn ? -b : b;
    rem = 0; d0 = 1'b0; ov = 1'b0; t = 2; r = 0;
    case (o)
      0: r = sa + sb;
      1: r = sa - sb;
      2: begin r = sa * sb; t = W + 1; end
      default: begin
        if (b == 0) d0 = 1'b1;
        else begin
          r = (an ^ bn) ? -(a / b) : (a / b);
          rem = a % b;
          t = W + 1;
        end
      end
    endcase
    mag = (r < 0) ? -r : r;
    neg = (r < 0);
    if (mag > MAX) begin ov = 1'b1; mag = MAX; end
  endfunction

  task automatic do_op(input string tag, input int o, input longint a, input bit an,
                       input longint b, input bit bn, input longint em, input bit en,
                       input longint er, input bit eo, input bit ed, input int et);
    int seen;
    @(negedge clk);
    op = 2'(o); a_mag = W'(a); a_neg = an; b_mag = W'(b); b_neg = bn; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    op = 2'($urandom); a_mag = W'($urandom); b_mag = W'($urandom);
    a_neg = 1'($urandom); b_neg = 1'($urandom);
    chk({tag, " busy_t1"}, busy, 1);
    chk({tag, " ovf_clr_t1"}, ovf, 0);
    chk({tag, " div0_clr_t1"}, div0, 0);
    chk({tag, " hold_t1"}, res_mag, last_mag);
    seen = 0;
    for (int k = 2; k <= W + 10 && seen == 0; k++) begin
      @(negedge clk);
      if (done) begin
        seen = k;
        chk({tag, " busy_at_done"}, busy, 0);
      end
    end
    chk({tag, " done_time"}, seen, et);
    chk({tag, " res_mag"}, res_mag, em);
    chk({tag, " res_neg"}, res_neg, en);
    chk({tag, " rem_mag"}, rem_mag, er);
    chk({tag, " ovf"}, ovf, eo);
    chk({tag, " div0"}, div0, ed);
    $display("[TB] %s op=%0d a=%0s%0d b=%0s%0d -> mag=%0d neg=%0d rem=%0d ovf=%0d div0=%0d done@T%0d",
             tag, o, an ? "-" : "", a, bn ? "-" : "", b, res_mag, res_neg, rem_mag, ovf, div0, seen);
    @(negedge clk);
    chk({tag, " done_one_cycle"}, done, 0);
    last_mag = em;
    last_neg = en;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " done"}, done, 0);
    chk({tag, " res_mag"}, res_mag, 0);
    chk({tag, " res_neg"}, res_neg, 0);
    chk({tag, " rem_mag"}, rem_mag, 0);
    chk({tag, " ovf"}, ovf, 0);
    chk({tag, " div0"}, div0, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int     ndone, first;
    longint ra, rb, em, er;
    bit     ran, rbn, en, eo, ed;
    int     ro, et;

    tbl[0]  = '{"add_12_30",      0, 12,       0, 30,       0, 42,      0, 0, 0, 0, 2};
    tbl[1]  = '{"sub_5_9",        1, 5,        0, 9,        0, 4,       1, 0, 0, 0, 2};
    tbl[2]  = '{"sub_7_7",        1, 7,        0, 7,        0, 0,       0, 0, 0, 0, 2};
    tbl[3]  = '{"mul_1234_n5678", 2, 1234,     0, 5678,     1, 7006652, 1, 0, 0, 0, 25};
    tbl[4]  = '{"mul_ovf",        2, 10000,    0, 1000,     0, 9999999, 0, 0, 1, 0, 25};
    tbl[5]  = '{"div_100_7",      3, 100,      0, 7,        0, 14,      0, 2, 0, 0, 25};
    tbl[6]  = '{"div_5_0",        3, 5,        0, 0,        0, 0,       0, 0, 0, 1, 2};
    tbl[7]  = '{"add_n3_3",       0, 3,        1, 3,        0, 0,       0, 0, 0, 0, 2};
    tbl[8]  = '{"add_ovf",        0, 9999990,  0, 10,       0, 9999999, 0, 0, 1, 0, 2};
    tbl[9]  = '{"sub_n5_n9",      1, 5,        1, 9,        1, 4,       0, 0, 0, 0, 2};
    tbl[10] = '{"div_n100_7",     3, 100,      1, 7,        0, 14,      1, 2, 0, 0, 25};
    tbl[11] = '{"mul_0_n5",       2, 0,        0, 5,        1, 0,       0, 0, 0, 0, 25};
    tbl[12] = '{"mul_full_ovf",   2, 16777215, 0, 16777215, 0, 9999999, 0, 0, 1, 0, 25};
    tbl[13] = '{"div_big_n1",     3, 16777215, 0, 1,        1, 9999999, 1, 0, 1, 0, 25};
    tbl[14] = '{"add_max_0",      0, 9999999,  0, 0,        0, 9999999, 0, 0, 0, 0, 2};
    tbl[15] = '{"sub_n4_6",       1, 4,        1, 6,        0, 10,      1, 0, 0, 0, 2};

    // reset state
    @(negedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++)
      do_op(tbl[i].name, tbl[i].op, tbl[i].a, tbl[i].an, tbl[i].b, tbl[i].bn,
            tbl[i].mag, tbl[i].neg, tbl[i].rem, tbl[i].ovf, tbl[i].d0, tbl[i].t);

    // start while busy is ignored
    @(negedge clk);
    op = 2'd2; a_mag = W'(1234); a_neg = 1'b0; b_mag = W'(5678); b_neg = 1'b1; start = 1'b1;
    ndone = 0; first = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      start = (k == 5);
      if (k == 5) begin op = 2'd0; a_mag = W'(1); b_mag = W'(1); b_neg = 1'b0; end
      if (done) begin ndone++; if (first == 0) first = k; end
    end
    chk("busy_start done_count", ndone, 1);
    chk("busy_start done_time", first, 25);
    chk("busy_start res_mag", res_mag, 7006652);
    chk("busy_start res_neg", res_neg, 1);
    $display("[TB] busy_start dones=%0d first@T%0d mag=%0d", ndone, first, res_mag);
    last_mag = 7006652; last_neg = 1'b1;

    // clear mid-multiply
    @(negedge clk);
    op = 2'd2; a_mag = W'(10); a_neg = 1'b0; b_mag = W'(10); b_neg = 1'b0; start = 1'b1;
    ndone = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 11) chk("clear busy_t11", busy, 0);
      clear = (k == 10);
      if (done) ndone++;
    end
    chk("clear done_count", ndone, 0);
    chk("clear res_mag_hold", res_mag, last_mag);
    chk("clear res_neg_hold", res_neg, last_neg);
    $display("[TB] clear_mid_mul dones=%0d mag=%0d", ndone, res_mag);

    // start and clear together
    @(negedge clk);
    op = 2'd0; a_mag = W'(1); b_mag = W'(1); start = 1'b1; clear = 1'b1;
    @(negedge clk);
    start = 1'b0; clear = 1'b0;
    chk("start_clear busy", busy, 0);
    ndone = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("start_clear done_count", ndone, 0);
    chk("start_clear res_mag_hold", res_mag, last_mag);
    $display("[TB] start_clear dones=%0d mag=%0d", ndone, res_mag);

    // reset mid-divide
    @(negedge clk);
    op = 2'd3; a_mag = W'(100); a_neg = 1'b0; b_mag = W'(7); b_neg = 1'b0; start = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("rst_mid busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("rst_mid done_after_release", ndone, 0);
    $display("[TB] reset_mid_div dones_after=%0d", ndone);
    last_mag = 0; last_neg = 1'b0;
    do_op("add_1_1_after_rst", 0, 1, 0, 1, 0, 2, 0, 0, 0, 0, 2);

    // randomized operations against the model
    for (int i = 0; i < 40; i++) begin
      ro  = int'($urandom_range(0, 3));
      ra  = $urandom_range(0, 1) ? longint'($urandom_range(0, 16777215)) : longint'($urandom_range(0, 5000));
      rb  = $urandom_range(0, 1) ? longint'($urandom_range(0, 16777215)) : longint'($urandom_range(0, 5000));
      if ($urandom_range(0, 9) == 0) rb = 0;
      ran = 1'($urandom);
      rbn = 1'($urandom);
      model(ro, ra, ran, rb, rbn, em, en, er, eo, ed, et);
      do_op($sformatf("rand%0d", i), ro, ra, ran, rb, rbn, em, en, er, eo, ed, et);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameter W, default 24, giving the operand/result magnitude width in bits.
REQ-002 SHALL have parameter MAX, default 9999999, giving the largest legal result magnitude (7-digit display limit).
REQ-003 clk  in  1  single clock (debounce-domain clock); all state updates on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 start  in  1  one-cycle request; sampled only in IDLE.
REQ-006 clear  in  1  synchronous abort; return to IDLE.
REQ-007 op  in  2  00 add, 01 sub, 10 mul, 11 div.
REQ-008 a_mag, b_mag  in  W  unsigned operand magnitudes; a_neg, b_neg  in  1  operand signs (sign-magnitude).
REQ-009 busy  out  1  high while an operation is in progress.
REQ-010 done  out  1  one-cycle completion pulse.
REQ-011 res_mag  out  W  result magnitude; res_neg  out  1  result sign; rem_mag  out  W  division remainder magnitude.
REQ-012 ovf  out  1  result exceeded MAX; div0  out  1  division by zero.

Function
REQ-013 SHALL implement states IDLE, RUN, DONE; the cycle in which start is sampled is T0.
REQ-014 IDLE with start=1 SHALL capture all operands and op at T0, enter RUN, and drive busy=1 from T1.
REQ-015 start SHALL be ignored outside IDLE; no queuing.
REQ-016 add/sub: effective sign of b = b_neg XOR op[0]; equal signs -> res_mag = a+b, res_neg = a_neg; otherwise res_mag = |a-b|, res_neg = sign of the larger magnitude; one RUN cycle; done at T2.
REQ-017 mul: shift-add over a single shared 2W-bit accumulator, one multiplier bit per cycle; W RUN cycles; done at T(W+1); res_neg = a_neg XOR b_neg.
REQ-018 div: restoring division, one quotient bit per cycle; W RUN cycles; done at T(W+1); res_mag = quotient, rem_mag = remainder; res_neg = a_neg XOR b_neg; rem sign not reported.
REQ-019 div with b_mag=0: SHALL skip iteration, set div0=1, res_mag=0, rem_mag=0, res_neg=0, done at T2.
REQ-020 Any result magnitude > MAX (including a mul product wider than W bits) SHALL set ovf=1 and force res_mag=MAX, keeping the computed sign.
REQ-021 A zero result SHALL force res_neg=0.
REQ-022 rem_mag SHALL be 0 for all non-div ops.
REQ-023 DONE SHALL last exactly one cycle, with done=1 and busy=0; the next state is IDLE.
REQ-024 res_mag, res_neg, rem_mag, ovf and div0 SHALL become valid at the done cycle and hold until the next accepted start, which clears ovf and div0 at T1.
REQ-025 clear=1 SHALL take priority over start and over iteration, move to IDLE next cycle with busy=0, suppress done, and leave the result outputs unchanged.
REQ-026 start and clear asserted in the same cycle SHALL result in clear only.
REQ-027 Operand changes after T0 SHALL NOT affect the in-flight result.

Reset
REQ-028 rst_n=0 SHALL immediately force state IDLE and busy, done, res_mag, res_neg, rem_mag, ovf, div0 to 0, and clear the accumulator and iteration counter.
REQ-029 Reset asserted mid-operation SHALL abandon that operation; no done pulse follows the release of reset.
REQ-030 The first start after rst_n deasserts SHALL be accepted normally.

Verification
REQ-031 add 12 + 30 (both positive), start at T0 -> busy at T1, done at T2, res_mag=42, res_neg=0, ovf=0.
REQ-032 sub 5 - 9 -> res_mag=4, res_neg=1; sub 7 - 7 -> res_mag=0, res_neg=0.
REQ-033 mul 1234 x (-5678) -> done at T25, res_mag=7006652, res_neg=1; mul 10000 x 1000 -> ovf=1, res_mag=9999999.
REQ-034 div 100 / 7 -> done at T25, res_mag=14, rem_mag=2; div 5 / 0 -> done at T2, div0=1, res_mag=0.
REQ-035 start while busy during a mul -> ignored, single done at T25; clear at T10 -> busy=0 at T11, no done pulse, outputs retain the previous result.
REQ-036 rst_n low at T12 of a div -> all outputs 0 asynchronously; after release, add 1 + 1 -> res_mag=2, done at T2.
